step_sequencer: RTL
===================

Name: step_sequencer

Overview:
- Drum-pattern step sequencer, directly downstream of the clock divider.
- Consumes the divider's divided clock level (tick_in) in the system clock domain and counts its rising edges into musical steps.
- At each step entry, fires one fixed-length trigger pulse per voice whose pattern bit is set.
- Outputs feed the per-voice sample players; pattern bits are written by the control/UI block.

Parameters:
- NUM_VOICES, 4, number of drum voices (1..8).
- NUM_STEPS, 16, steps per pattern loop (2..32).
- TICKS_PER_STEP, 6, tick_in rising edges per step (>=2).
- TRIG_LEN, 4, trigger pulse width in clk_rx cycles (>=1).
- SWING_TICKS, 2, swing offset in ticks; used only with SWING_EN; must be < TICKS_PER_STEP.

Ports:
- clk_rx  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- tick_in  in  1  divided clock level from the divider; same clock domain, no synchroniser.
- start  in  1  one-cycle command: begin or resume playback.
- stop  in  1  one-cycle command: halt and rewind.
- pause  in  1  one-cycle command: freeze position.
- wr_en  in  1  pattern write strobe.
- wr_voice  in  clog2(NUM_VOICES)  voice index for the write.
- wr_step  in  clog2(NUM_STEPS)  step index for the write.
- wr_data  in  1  pattern bit value.
- trig  out  NUM_VOICES  per-voice trigger pulses.
- step_idx  out  clog2(NUM_STEPS)  current step.
- playing  out  1  high in RUN.

Behaviour:
- Interface: one clock, clk_rx. Reset rst is synchronous and active-high.
- Reset state:
  - trig=0, step_idx=0, playing=0, state=IDLE, tick counter=0.
  - Pattern memory is cleared to all zeros; reset takes one cycle.
  - Reset mid-playback aborts any active pulses in the same cycle.
- Edge detect:
  - tick_q is registered from tick_in.
  - tick_edge = tick_in & ~tick_q.
  - tick_q resets to 1, so a tick_in held high during reset does not produce an edge.
- FSM states: IDLE, RUN, PAUSE.
- IDLE:
  - start -> RUN; step_idx=0; tick counter=0.
  - Step-0 triggers assert in the cycle after start.
  - Other commands are ignored.
- RUN:
  - Each tick_edge increments the tick counter.
  - When the counter reaches step length minus 1 and a tick_edge occurs:
    - counter wraps to 0;
    - step_idx increments, wrapping from NUM_STEPS-1 to 0;
    - triggers for the new step assert in the next cycle, the same cycle step_idx updates.
  - Latency from qualifying tick_edge to trig/step_idx change is 1 cycle.
- PAUSE:
  - Counter and step_idx are frozen; tick_edges are ignored.
  - start -> RUN with no re-trigger. Counting continues from the frozen value.
- stop from RUN or PAUSE:
  - -> IDLE; step_idx=0; counter=0; all trig forced 0 in the next cycle.
- Command priority when asserted together: stop > pause > start.
  - pause in IDLE is ignored. start in RUN is ignored.
- Trigger pulses:
  - Each voice has an independent TRIG_LEN down-counter.
  - A pulse is high for exactly TRIG_LEN cycles.
  - A retrigger during an active pulse reloads the count, extending the pulse without a gap.
  - Pulses already running when PAUSE is entered complete normally.
- Pattern memory:
  - NUM_VOICES x NUM_STEPS bits; written when wr_en is high, in any state.
  - Trigger evaluation reads the registered pattern value before a same-cycle write takes effect (old data).
  - The new value is heard on the next visit to that step.
- Width rules:
  - tick counter width is clog2(TICKS_PER_STEP+SWING_TICKS+1).
  - Out-of-range wr_voice or wr_step (non-power-of-2 sizes) is ignored; the write is dropped.

Optional Feature:
- Macro: STEP_SEQUENCER_SWING_EN.
- Defined:
  - Even steps last TICKS_PER_STEP+SWING_TICKS ticks; odd steps last TICKS_PER_STEP-SWING_TICKS.
  - Total pair length is unchanged.
- Undefined: every step lasts TICKS_PER_STEP ticks. SWING_TICKS is unused; no swing logic is synthesised.

Decomposition:
- Package drum_seq_pkg:
  - state enum seq_state_t {IDLE, RUN, PAUSE};
  - width helper constants: voice-index, step-index and tick-counter widths;
  - default parameter constants.
- Sub-module trig_pulse: one instance per voice via generate. Holds the TRIG_LEN down-counter and implements retrigger reload.
- Pattern memory, FSM and tick counting stay in step_sequencer.

Test Plan:
- Reset release with tick_in high, then 10 cycles idle -> trig=0, step_idx=0, playing=0; no step advance.
- Write voice0 steps 0 and 4, voice1 step 2; start; drive 30 tick edges.
  - Required: voice0 4-cycle pulse 1 cycle after start.
  - step_idx=1 after 6 edges.
  - voice1 pulse at step 2; voice0 pulse at step 4; no others.
- Run to step 15 and supply 6 more edges -> step_idx wraps to 0; voice0 fires again.
- pause at step 3, 12 tick edges, then start -> step_idx stays 3 throughout pause; advances to 4 after the remaining tick count, with no extra trigger on resume.
- Assert start+stop together in RUN -> IDLE; step_idx=0; trig cleared next cycle.
- With STEP_SEQUENCER_SWING_EN, TICKS_PER_STEP=6, SWING_TICKS=2 -> step 0 lasts 8 edges, step 1 lasts 4 edges; step_idx=2 after exactly 12 edges.

Source files
------------

// File: rtl/drum_seq_pkg.sv
// Shared types, default sizes and index-width helpers for the drum step sequencer.
package drum_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} seq_state_t;

  localparam int unsigned DEF_NUM_VOICES     = 4;
  localparam int unsigned DEF_NUM_STEPS      = 16;
  localparam int unsigned DEF_TICKS_PER_STEP = 6;
  localparam int unsigned DEF_TRIG_LEN       = 4;
  localparam int unsigned DEF_SWING_TICKS    = 2;

  // Index width for n entries; never below one bit so single-entry sizes stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Tick counter must hold the longest (swung) step length.
  function automatic int unsigned tick_cnt_w(input int unsigned tps, input int unsigned swing);
    return idx_w(tps + swing + 1);
  endfunction

  localparam int unsigned VOICE_W = idx_w(DEF_NUM_VOICES);
  localparam int unsigned STEP_W  = idx_w(DEF_NUM_STEPS);
  localparam int unsigned TICK_W  = tick_cnt_w(DEF_TICKS_PER_STEP, DEF_SWING_TICKS);

endpackage

// File: rtl/step_sequencer_trig_pulse.sv
// Per-voice fixed-length trigger pulse; a fire during an active pulse reloads the length.
module trig_pulse
  import drum_seq_pkg::*;
#(
  parameter int unsigned TRIG_LEN = DEF_TRIG_LEN
) (
  input  logic clk_rx,
  input  logic rst,
  input  logic clear,
  input  logic fire,
  output logic pulse
);

  localparam int unsigned CW = idx_w(TRIG_LEN);

  // Cycles still to run after the current one.
  logic [CW-1:0] remain;

  always_ff @(posedge clk_rx) begin
    if (rst || clear) begin
      remain <= '0;
      pulse  <= 1'b0;
    end else if (fire) begin
      remain <= CW'(TRIG_LEN - 1);
      pulse  <= 1'b1;
    end else if (remain != '0) begin
      remain <= remain - CW'(1);
      pulse  <= 1'b1;
    end else begin
      pulse  <= 1'b0;
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Drum step sequencer: counts tick_in rising edges into steps and fires per-voice triggers.
// Optional swing timing is enabled with `define STEP_SEQUENCER_SWING_EN.
module step_sequencer
  import drum_seq_pkg::*;
#(
  parameter int unsigned NUM_VOICES     = DEF_NUM_VOICES,
  parameter int unsigned NUM_STEPS      = DEF_NUM_STEPS,
  parameter int unsigned TICKS_PER_STEP = DEF_TICKS_PER_STEP,
  parameter int unsigned TRIG_LEN       = DEF_TRIG_LEN,
  parameter int unsigned SWING_TICKS    = DEF_SWING_TICKS
) (
  input  logic                          clk_rx,
  input  logic                          rst,
  input  logic                          tick_in,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          pause,
  input  logic                          wr_en,
  input  logic [idx_w(NUM_VOICES)-1:0]  wr_voice,
  input  logic [idx_w(NUM_STEPS)-1:0]   wr_step,
  input  logic                          wr_data,
  output logic [NUM_VOICES-1:0]         trig,
  output logic [idx_w(NUM_STEPS)-1:0]   step_idx,
  output logic                          playing
);

  localparam int unsigned VW = idx_w(NUM_VOICES);
  localparam int unsigned SW = idx_w(NUM_STEPS);
  localparam int unsigned CW = tick_cnt_w(TICKS_PER_STEP, SWING_TICKS);

`ifdef STEP_SEQUENCER_SWING_EN
  localparam int unsigned EVEN_LAST = TICKS_PER_STEP + SWING_TICKS - 1;
  localparam int unsigned ODD_LAST  = TICKS_PER_STEP - SWING_TICKS - 1;
`else
  localparam int unsigned STEP_LAST = TICKS_PER_STEP - 1;
`endif

  seq_state_t                          state, state_nxt;
  logic                                tick_q;
  logic                                tick_edge_c;
  logic [CW-1:0]                       tick_cnt, tick_cnt_nxt;
  logic [CW-1:0]                       step_last_c;
  logic [SW-1:0]                       step_nxt;
  logic                                fire_c;
  logic                                clear_c;
  logic [NUM_VOICES-1:0]               fire_vec_c;
  logic [NUM_STEPS-1:0][NUM_VOICES-1:0] pattern;
  logic                                voice_ok_c;
  logic                                step_ok_c;

  assign tick_edge_c = tick_in & ~tick_q;

`ifdef STEP_SEQUENCER_SWING_EN
  assign step_last_c = step_idx[0] ? CW'(ODD_LAST) : CW'(EVEN_LAST);
`else
  assign step_last_c = CW'(STEP_LAST);
`endif

  // Writes to indices beyond a non-power-of-two size are dropped.
  if (NUM_VOICES == (2 ** VW)) begin : g_voice_full
    assign voice_ok_c = 1'b1;
  end else begin : g_voice_part
    assign voice_ok_c = (32'(wr_voice) < NUM_VOICES);
  end

  if (NUM_STEPS == (2 ** SW)) begin : g_step_full
    assign step_ok_c = 1'b1;
  end else begin : g_step_part
    assign step_ok_c = (32'(wr_step) < NUM_STEPS);
  end

  always_ff @(posedge clk_rx) begin
    if (rst) begin
      pattern <= '0;
    end else if (wr_en && voice_ok_c && step_ok_c) begin
      pattern[wr_step][wr_voice] <= wr_data;
    end
  end

  // Next-state, position and trigger-fire decode; stop > pause > start.
  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    step_nxt     = step_idx;
    fire_c       = 1'b0;
    clear_c      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = RUN;
          tick_cnt_nxt = '0;
          step_nxt     = '0;
          fire_c       = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt    = IDLE;
          tick_cnt_nxt = '0;
          step_nxt     = '0;
          clear_c      = 1'b1;
        end else if (pause) begin
          state_nxt = PAUSE;
        end else if (tick_edge_c) begin
          if (tick_cnt == step_last_c) begin
            tick_cnt_nxt = '0;
            step_nxt     = (step_idx == SW'(NUM_STEPS - 1)) ? '0 : step_idx + SW'(1);
            fire_c       = 1'b1;
          end else begin
            tick_cnt_nxt = tick_cnt + CW'(1);
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_nxt    = IDLE;
          tick_cnt_nxt = '0;
          step_nxt     = '0;
          clear_c      = 1'b1;
        end else if (start) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pattern is read before any same-cycle write lands, so new data is heard next visit.
  assign fire_vec_c = fire_c ? pattern[step_nxt] : '0;

  always_ff @(posedge clk_rx) begin
    if (rst) begin
      state    <= IDLE;
      tick_q   <= 1'b1;
      tick_cnt <= '0;
      step_idx <= '0;
      playing  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_q   <= tick_in;
      tick_cnt <= tick_cnt_nxt;
      step_idx <= step_nxt;
      playing  <= (state_nxt == RUN);
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    trig_pulse #(
      .TRIG_LEN (TRIG_LEN)
    ) u_trig_pulse (
      .clk_rx (clk_rx),
      .rst    (rst),
      .clear  (clear_c),
      .fire   (fire_vec_c[v]),
      .pulse  (trig[v])
    );
  end

endmodule
